// File: rtl/seq_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// seq_muldiv_pkg
// Shared definitions for the iterative HI/LO multiply/divide unit.
//   - op encodings : OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
//   - state_t      : S_IDLE, S_CALC, S_FIX, S_DONE
//   - op_is_div / op_is_signed : decode helpers for the 2-bit op field
// -----------------------------------------------------------------------------
package seq_muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// Combinational single radix-2 iteration shared by multiply and divide.
//
// Accumulator layout (2*WIDTH+1 bits):
//   multiply : {partial product upper half (WIDTH+1), multiplier bits (WIDTH)}
//              the multiplier LSB selects the add, then everything shifts right.
//   divide   : {partial remainder (WIDTH+1), dividend/quotient bits (WIDTH)}
//              shift left, trial-subtract the divisor, restore on borrow.
//
// Ports:
//   acc_in   in  2*WIDTH+1  current accumulator
//   operand  in  WIDTH      multiplicand magnitude / divisor magnitude
//   div_mode in  1          0 = shift-add multiply, 1 = restoring divide
//   acc_out  out 2*WIDTH    next accumulator, bits [2*WIDTH:1]
//   bit_out  out 1          bit entering accumulator bit 0
//                           (next multiplier bit / new quotient bit)
// -----------------------------------------------------------------------------
module muldiv_step
    import seq_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_out,
    output logic               bit_out
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;

    always_comb begin
        mul_sum   = acc_in[2*WIDTH:WIDTH] + (acc_in[0] ? {1'b0, operand} : '0);
        // Remainder shifted left with the next dividend bit (MSB first).
        div_shift = acc_in[2*WIDTH-1:WIDTH-1];
        // One extra bit so the borrow of the trial subtraction is visible.
        div_diff  = {1'b0, div_shift} - {2'b00, operand};
        div_ok    = ~div_diff[WIDTH+1];
        acc_out   = '0;
        bit_out   = 1'b0;
        if (div_mode) begin
            acc_out = {(div_ok ? div_diff[WIDTH:0] : div_shift), acc_in[WIDTH-2:0]};
            bit_out = div_ok;
        end else begin
            acc_out = {1'b0, mul_sum, acc_in[WIDTH-1:2]};
            bit_out = acc_in[1];
        end
    end

endmodule

// File: rtl/seq_muldiv.sv
// -----------------------------------------------------------------------------
// seq_muldiv
// Iterative multiply/divide unit for the HI/LO path. One radix-2 step per
// clock: IDLE -> CALC (WIDTH cycles) -> FIX (1) -> DONE (1) -> IDLE.
// Latency is WIDTH+2 cycles from the start cycle for every op; a start in
// DONE is accepted back-to-back.
//
// Build option:
//   SEQ_MULDIV_DIV_EN defined   : signed/unsigned divide with div_zero flag.
//   SEQ_MULDIV_DIV_EN undefined : divider removed; DIV/DIVU still complete
//                                 with normal latency, giving hi=0, lo=0,
//                                 div_zero tied 0.
//
// Ports:
//   clk      in  1      rising-edge clock
//   rst_n    in  1      asynchronous active-low reset
//   start    in  1      request, accepted only while ready=1
//   op       in  2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a        in  WIDTH  multiplicand / dividend
//   b        in  WIDTH  multiplier / divisor
//   flush    in  1      abort an in-flight operation (CALC/FIX)
//   ready    out 1      high in IDLE and DONE
//   done     out 1      one-cycle pulse when hi/lo are updated
//   hi       out WIDTH  product upper half / remainder
//   lo       out WIDTH  product lower half / quotient
//   div_zero out 1      last divide had b=0, sticky until next accept
// -----------------------------------------------------------------------------
module seq_muldiv
    import seq_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    // Two's complement negate when 'neg' is set. The most negative value maps
    // onto itself, which read as unsigned is its exact magnitude 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_if_wide(input logic [2*WIDTH-1:0] x,
                                                        input logic neg);
        return neg ? -x : x;
    endfunction

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                div_q;
    logic                neg_a_q;
    logic                neg_b_q;
    logic [WIDTH-1:0]    opnd_q;
    logic [2*WIDTH:0]    acc_q;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                accept;
    logic                sgn_a;
    logic                sgn_b;
    logic [WIDTH-1:0]    a_mag;
    logic [WIDTH-1:0]    b_mag;
    logic [WIDTH-1:0]    opnd_init;
    logic [WIDTH-1:0]    low_init;
    logic                div_mode;
    logic [2*WIDTH-1:0]  step_acc;
    logic                step_bit;
    logic [2*WIDTH-1:0]  prod;
    logic [WIDTH-1:0]    res_hi;
    logic [WIDTH-1:0]    res_lo;

    assign a_s    = a;
    assign b_s    = b;
    // flush wins over start while ready.
    assign accept = ready && start && !flush;
    assign sgn_a  = op_is_signed(op) && (a_s < 0);
    assign sgn_b  = op_is_signed(op) && (b_s < 0);
    assign a_mag  = neg_if(a, sgn_a);
    assign b_mag  = neg_if(b, sgn_b);

`ifdef SEQ_MULDIV_DIV_EN
    logic [WIDTH-1:0] a_q;
    logic             bz_q;

    // Multiply shifts the multiplier through the low half; divide shifts the
    // dividend through it and accumulates the remainder above.
    assign opnd_init = op_is_div(op) ? b_mag : a_mag;
    assign low_init  = op_is_div(op) ? a_mag : b_mag;
    assign div_mode  = div_q;
`else
    assign opnd_init = a_mag;
    assign low_init  = b_mag;
    assign div_mode  = 1'b0;
    assign div_zero  = 1'b0;
`endif

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_in   (acc_q),
        .operand  (opnd_q),
        .div_mode (div_mode),
        .acc_out  (step_acc),
        .bit_out  (step_bit)
    );

    // Sign fix-up of the finished magnitudes, consumed in FIX.
    always_comb begin
        prod   = neg_if_wide(acc_q[2*WIDTH-1:0], neg_a_q ^ neg_b_q);
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
`ifdef SEQ_MULDIV_DIV_EN
        if (div_q) begin
            if (bz_q) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                // Quotient takes sign(a)^sign(b), remainder takes sign(a).
                // -2^(W-1) / -1 wraps to lo = a, hi = 0 with no special case.
                res_hi = neg_if(acc_q[2*WIDTH-1:WIDTH], neg_a_q);
                res_lo = neg_if(acc_q[WIDTH-1:0], neg_a_q ^ neg_b_q);
            end
        end
`else
        if (div_q) begin
            res_hi = '0;
            res_lo = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            div_q   <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
`ifdef SEQ_MULDIV_DIV_EN
            a_q      <= '0;
            bz_q     <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state   <= S_CALC;
                        ready   <= 1'b0;
                        cnt     <= '0;
                        div_q   <= op_is_div(op);
                        neg_a_q <= sgn_a;
                        neg_b_q <= sgn_b;
                        opnd_q  <= opnd_init;
                        acc_q   <= {{(WIDTH+1){1'b0}}, low_init};
`ifdef SEQ_MULDIV_DIV_EN
                        a_q      <= a;
                        bz_q     <= (b == '0);
                        div_zero <= 1'b0;
`endif
                    end else begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        acc_q <= {step_acc, step_bit};
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= S_FIX;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_FIX: begin
                    ready <= 1'b1;
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        hi    <= res_hi;
                        lo    <= res_lo;
`ifdef SEQ_MULDIV_DIV_EN
                        div_zero <= div_q && bz_q;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_muldiv.sv
module tb_seq_muldiv;
    import seq_muldiv_pkg::*;

    localparam int W = 32;
`ifdef SEQ_MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic         ready, done, div_zero;
    logic [W-1:0] hi, lo;

    logic         s8 = 1'b0;
    logic [1:0]   op8 = 2'b00;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic         fl8 = 1'b0;
    logic         r8, d8, dz8;
    logic [7:0]   h8, l8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_muldiv #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .ready(ready), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    seq_muldiv #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .op(op8), .a(a8), .b(b8), .flush(fl8),
        .ready(r8), .done(d8), .hi(h8), .lo(l8), .div_zero(dz8)
    );

    // Issue one operation from the current cycle and wait for done.
    // Operands are scrambled right after the accept edge.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat);
        op = o; a = x; b = y; start = 1'b1; lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                start = 1'b0; a = ~x; b = ~y; op = ~o;
            end
            if (done) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        int lat;
        run_op(OP_MULT, 32'd16, 32'd3, lat);
        checks++; if (lat != 34) begin errors++; $display("FAIL mul16x3_lat got=%0d exp=34", lat); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mul16x3_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h30) begin errors++; $display("FAIL mul16x3_lo got=%h exp=30", lo); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got=%b exp=0", done); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", ready); end
        checks++; if (lo !== 32'h30) begin errors++; $display("FAIL hold_lo got=%h exp=30", lo); end

        run_op(OP_MULT, 32'hFFFFFFFF, 32'd2, lat);
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mul_m1x2_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL mul_m1x2_lo got=%h exp=fffffffe", lo); end

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulu_max_hi got=%h exp=fffffffe", hi); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL mulu_max_lo got=%h exp=1", lo); end

        run_op(OP_MULT, 32'h80000000, 32'h80000000, lat);
        checks++; if (hi !== 32'h40000000) begin errors++; $display("FAIL mul_minmin_hi got=%h exp=40000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mul_minmin_lo got=%h exp=0", lo); end

        run_op(OP_MULT, 32'h80000000, 32'hFFFFFFFF, lat);
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mul_minm1_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL mul_minm1_lo got=%h exp=80000000", lo); end

        run_op(OP_MULTU, 32'h80000000, 32'd2, lat);
        checks++; if (hi !== 32'h1) begin errors++; $display("FAIL mulu_big_hi got=%h exp=1", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mulu_big_lo got=%h exp=0", lo); end

        run_op(OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, lat);
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mul_negneg_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'hF) begin errors++; $display("FAIL mul_negneg_lo got=%h exp=f", lo); end
    endtask

    task automatic test_div();
        int lat;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat);
        checks++; if (lat != 34) begin errors++; $display("FAIL div_lat got=%0d exp=34", lat); end
        checks++; if (lo !== (DIV_ON ? 32'hFFFFFFFD : 32'h0)) begin errors++; $display("FAIL div_m7_2_lo got=%h", lo); end
        checks++; if (hi !== (DIV_ON ? 32'hFFFFFFFF : 32'h0)) begin errors++; $display("FAIL div_m7_2_hi got=%h", hi); end

        run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, lat);
        checks++; if (lo !== (DIV_ON ? 32'hFFFFFFFD : 32'h0)) begin errors++; $display("FAIL div_7_m2_lo got=%h", lo); end
        checks++; if (hi !== (DIV_ON ? 32'h1 : 32'h0)) begin errors++; $display("FAIL div_7_m2_hi got=%h", hi); end

        run_op(OP_DIVU, 32'd5, 32'd0, lat);
        checks++; if (lat != 34) begin errors++; $display("FAIL divz_lat got=%0d exp=34", lat); end
        checks++; if (lo !== (DIV_ON ? 32'hFFFFFFFF : 32'h0)) begin errors++; $display("FAIL divz_lo got=%h", lo); end
        checks++; if (hi !== (DIV_ON ? 32'h5 : 32'h0)) begin errors++; $display("FAIL divz_hi got=%h", hi); end
        checks++; if (div_zero !== DIV_ON) begin errors++; $display("FAIL divz_flag got=%b exp=%b", div_zero, DIV_ON); end
        @(posedge clk); #1;
        checks++; if (div_zero !== DIV_ON) begin errors++; $display("FAIL divz_sticky got=%b exp=%b", div_zero, DIV_ON); end

        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
        checks++; if (lo !== (DIV_ON ? 32'h80000000 : 32'h0)) begin errors++; $display("FAIL div_ovf_lo got=%h", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_ovf_flag got=%b exp=0", div_zero); end

        run_op(OP_DIVU, 32'd100, 32'd7, lat);
        checks++; if (lo !== (DIV_ON ? 32'd14 : 32'h0)) begin errors++; $display("FAIL divu_100_7_lo got=%h", lo); end
        checks++; if (hi !== (DIV_ON ? 32'd2 : 32'h0)) begin errors++; $display("FAIL divu_100_7_hi got=%h", hi); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(OP_MULTU, 32'd10, 32'd20, lat);
        checks++; if (lo !== 32'd200) begin errors++; $display("FAIL b2b_first_lo got=%h exp=c8", lo); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_done got=%b exp=1", ready); end
        run_op(OP_MULT, 32'd7, 32'hFFFFFFFD, lat);
        checks++; if (lat != 34) begin errors++; $display("FAIL b2b_lat got=%0d exp=34", lat); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL b2b_lo got=%h exp=ffffffeb", lo); end
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        run_op(OP_MULTU, 32'd3, 32'd4, lat);
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL pre_flush_lo got=%h exp=c", lo); end
        @(posedge clk); #1;
        op = OP_MULT; a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready got=%b exp=0", ready); end
        op = OP_MULTU; a = 32'd100; b = 32'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", ready); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL flush_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL flush_lo got=%h exp=c", lo); end

        op = OP_MULT; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flushwins_ready got=%b exp=1", ready); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL flushwins_no_done got=%0d exp=0", seen); end
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL flushwins_lo got=%h exp=c", lo); end
    endtask

    task automatic test_async_reset();
        int lat;
        op = OP_MULT; a = 32'd123; b = 32'd456; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL arst_ready got=%b exp=1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done got=%b exp=0", done); end
        checks++; if (hi !== '0) begin errors++; $display("FAIL arst_hi got=%h exp=0", hi); end
        checks++; if (lo !== '0) begin errors++; $display("FAIL arst_lo got=%h exp=0", lo); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(OP_MULT, 32'd16, 32'd3, lat);
        checks++; if (lat != 34) begin errors++; $display("FAIL arst_recover_lat got=%0d exp=34", lat); end
        checks++; if (lo !== 32'h30) begin errors++; $display("FAIL arst_recover_lo got=%h exp=30", lo); end
    endtask

    task automatic test_width8();
        int lat;
        op8 = OP_MULT; a8 = 8'd16; b8 = 8'd3; s8 = 1'b1; lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) s8 = 1'b0;
            if (d8) break;
        end
        checks++; if (lat != 10) begin errors++; $display("FAIL w8_lat got=%0d exp=10", lat); end
        checks++; if (l8 !== 8'h30) begin errors++; $display("FAIL w8_lo got=%h exp=30", l8); end
        checks++; if (h8 !== 8'h00) begin errors++; $display("FAIL w8_hi got=%h exp=0", h8); end
        op8 = OP_MULT; a8 = 8'hFF; b8 = 8'd2; s8 = 1'b1; lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) s8 = 1'b0;
            if (d8) break;
        end
        checks++; if (h8 !== 8'hFF) begin errors++; $display("FAIL w8_m1x2_hi got=%h exp=ff", h8); end
        checks++; if (l8 !== 8'hFE) begin errors++; $display("FAIL w8_m1x2_lo got=%h exp=fe", l8); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_width8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
